i2c_slave: RTL and testbench
============================

Name: i2c_slave

Overview:
- I2C target that sits on the far side of the bus from i2c_master and consumes its SCL/SDA traffic.
- Detects START/STOP, matches a 7-bit address and ACKs it, then either receives bytes into the local fabric or returns bytes to the master.
- Used as the bus-side model/peer for master bring-up and as a synthesizable register-port front end.

Parameters:
- ADDR, 7'h42, device address compared against the first byte after START.
- SYNC_STAGES, 2, flip-flop depth of the SCL/SDA input synchronizers (minimum 2).

Ports:
- clk_i  in  1  system clock; must be at least 8x the SCL rate.
- rst_i  in  1  reset, synchronous, active-high.
- scl_i  in  1  bus SCL level, asynchronous.
- sda_i  in  1  bus SDA level, asynchronous.
- sda_oe_o  out  1  1 = pull SDA low (open-drain); 0 = release.
- rx_data_o  out  8  last received data byte.
- rx_valid_o  out  1  one-cycle pulse; rx_data_o is new.
- rx_ack_i  in  1  sampled with rx_valid_o: 1 = ACK the byte, 0 = NACK.
- tx_data_i  in  8  byte to return on a read.
- tx_load_o  out  1  one-cycle pulse; tx_data_i is captured this cycle.
- busy_o  out  1  high while addressed (ADDR_ACK through the end of the transfer).

Behaviour:
- Reset values: sda_oe_o=0, rx_data_o=0, rx_valid_o=0, tx_load_o=0, busy_o=0, state=IDLE, bit counter=0.
- Input path:
  - scl_i and sda_i each pass through SYNC_STAGES flops.
  - Edges are detected on the synchronized signals against a one-cycle-delayed copy.
  - Every event listed below is therefore seen SYNC_STAGES+1 clk after the pin changes.
- Bus conditions:
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - A data bit is sampled on the SCL rising edge, MSB first.
  - sda_oe_o changes only on an SCL falling edge (one clk after detection), never while SCL is high.
- States: IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, WAIT_STOP.
- IDLE: on START go to ADDR with bit counter=0.
- ADDR:
  - Shift 8 bits: 7 address bits followed by R/W in the LSB.
  - After the 8th rising edge, on the next falling edge:
    - Address equals ADDR: go to ADDR_ACK, sda_oe_o=1, busy_o=1.
    - Otherwise: go to WAIT_STOP with SDA released.
- ADDR_ACK, on the next falling edge:
  - R/W=0: go to RX and release SDA.
  - R/W=1: pulse tx_load_o, capture tx_data_i, go to TX, drive bit 7 (sda_oe_o = ~bit).
- RX:
  - Shift 8 bits.
  - One clk after the 8th rising edge: rx_data_o updates, rx_valid_o pulses, rx_ack_i is sampled.
  - On the next falling edge go to RX_ACK; sda_oe_o = sampled rx_ack_i.
- RX_ACK, on the next falling edge:
  - Release SDA.
  - Byte was ACKed: return to RX, counter=0.
  - Byte was NACKed: go to WAIT_STOP.
- TX:
  - On each falling edge drive the next bit.
  - After the 8th bit's falling edge go to TX_ACK with SDA released.
  - Sample the master's ACK on the rising edge.
- TX_ACK, on the next falling edge:
  - Master ACK (SDA low): pulse tx_load_o, load a new byte, go to TX.
  - Master NACK: go to WAIT_STOP.
- WAIT_STOP: SDA released, ignore bits until START or STOP.
- STOP in any state: go to IDLE next clk, sda_oe_o=0, busy_o=0.
- START in any state (including repeated START): go to ADDR, counter=0, sda_oe_o=0, busy_o=0.
- Simultaneous events: START/STOP take priority over bit sampling in the same clk.
- rst_i mid-transfer: return to IDLE and release SDA within 1 clk; a later STOP or START is handled normally.
- No data arrives between START and the 8th bit of any byte; a partial byte is discarded when START or STOP interrupts it.

Test Plan:
- Write to ADDR=7'h42 with data 8'hA5 (rx_ack_i=1), then STOP:
  - sda_oe_o=1 during the address ACK clock and the data ACK clock.
  - rx_valid_o pulses exactly once with rx_data_o=8'hA5.
  - busy_o drops one clk after STOP.
- Address 7'h43 write: sda_oe_o stays 0 for the whole transaction, no rx_valid_o, busy_o stays 0.
- Read from 7'h42 with tx_data_i=8'h3C, master ACKs, then tx_data_i=8'hC3, master NACKs, then STOP:
  - SDA bits observed are 0011_1100 followed by 1100_0011.
  - tx_load_o pulses twice.
  - State is IDLE after STOP.
- Write of 2 bytes (8'h01, 8'h02) with rx_ack_i=0 on the first byte:
  - First byte NACKed (sda_oe_o=0 during the ACK clock).
  - Second byte produces no rx_valid_o.
- Write 8'h55, repeated START, then read with tx_data_i=8'h99: rx_valid_o fires for 8'h55 and the read returns 8'h99 without an intervening STOP.
- Assert rst_i for 1 clk mid-way through the 4th bit of a read with SDA driven low: sda_oe_o=0 next clk, busy_o=0, and the next START+write transaction completes normally.

Source files
------------

// File: rtl/i2c_slave.sv
// I2C target: START/STOP detect, 7-bit address match + ACK, byte receive to fabric or byte return to master.
// Latency: every bus event acts SYNC_STAGES+1 clk after the pin change; rx_valid_o one clk after the 8th SCL rise.
// Backpressure: none on the fabric side; rx_ack_i=0 NACKs a byte and tx_load_o demands tx_data_i in that same cycle.
//
// Ports:
//   clk_i, rst_i        system clock (>= 8x SCL) and synchronous active-high reset
//   scl_i, sda_i        asynchronous bus levels
//   sda_oe_o            1 = pull SDA low (open-drain), 0 = release
//   rx_data_o           last received data byte
//   rx_valid_o          one-cycle pulse when rx_data_o is new
//   rx_ack_i            sampled with rx_valid_o: 1 = ACK, 0 = NACK
//   tx_data_i           byte returned on a read
//   tx_load_o           one-cycle pulse; tx_data_i captured this cycle
//   busy_o              high while addressed, until STOP or START
module i2c_slave #(
    parameter logic [6:0] ADDR        = 7'h42,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic       rx_ack_i,
    input  logic [7:0] tx_data_i,
    output logic       tx_load_o,
    output logic       busy_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_RX,
        S_RX_ACK,
        S_TX,
        S_TX_ACK,
        S_WAIT_STOP
    } state_t;

    // ---------------------------------------------------------------
    // Input synchronizers and edge/condition detection
    // ---------------------------------------------------------------
    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_prev_q;
    logic                   sda_prev_q;
    logic                   scl_s;
    logic                   sda_s;

    // Synchronizers reset to the idle-bus level so leaving reset never
    // fabricates an edge or a START/STOP.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
        end
    end

    assign scl_s = scl_sync_q[SYNC_STAGES-1];
    assign sda_s = sda_sync_q[SYNC_STAGES-1];

    logic scl_rise;
    logic scl_fall;
    logic start_evt;
    logic stop_evt;

    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    // SCL must be high on both samples so an SDA change that lands in the
    // same sync cycle as an SCL edge is not mistaken for START/STOP.
    assign start_evt = scl_s & scl_prev_q & ~sda_s & sda_prev_q;
    assign stop_evt  = scl_s & scl_prev_q & sda_s & ~sda_prev_q;

    // ---------------------------------------------------------------
    // Protocol FSM
    // ---------------------------------------------------------------
    state_t      state_q,    state_d;
    logic [3:0]  cnt_q,      cnt_d;
    logic [7:0]  shift_q,    shift_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic        rw_q,       rw_d;
    logic        ack_q,      ack_d;
    logic        mack_q,     mack_d;
    logic        oe_q,       oe_d;
    logic        busy_q,     busy_d;
    logic [7:0]  rx_data_q,  rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic        tx_load;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            shift_q    <= '0;
            tx_shift_q <= '0;
            rw_q       <= 1'b0;
            ack_q      <= 1'b0;
            mack_q     <= 1'b0;
            oe_q       <= 1'b0;
            busy_q     <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            tx_shift_q <= tx_shift_d;
            rw_q       <= rw_d;
            ack_q      <= ack_d;
            mack_q     <= mack_d;
            oe_q       <= oe_d;
            busy_q     <= busy_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        tx_shift_d = tx_shift_q;
        rw_d       = rw_q;
        ack_d      = ack_q;
        mack_d     = mack_q;
        oe_d       = oe_q;
        busy_d     = busy_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        tx_load    = 1'b0;

        // Fabric decides ACK/NACK in the cycle it sees the new byte.
        if (rx_valid_q) begin
            ack_d = rx_ack_i;
        end

        // Bus conditions outrank any bit event in the same cycle.
        if (start_evt) begin
            state_d = S_ADDR;
            cnt_d   = '0;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
        end else if (stop_evt) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                S_ADDR: begin
                    if (scl_rise && cnt_q < 4'd8) begin
                        shift_d = {shift_q[6:0], sda_s};
                        cnt_d   = cnt_q + 4'd1;
                    end else if (scl_fall && cnt_q == 4'd8) begin
                        if (shift_q[7:1] == ADDR) begin
                            state_d = S_ADDR_ACK;
                            rw_d    = shift_q[0];
                            oe_d    = 1'b1;
                            busy_d  = 1'b1;
                        end else begin
                            state_d = S_WAIT_STOP;
                            oe_d    = 1'b0;
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (scl_fall) begin
                        cnt_d = '0;
                        if (rw_q) begin
                            tx_load    = 1'b1;
                            tx_shift_d = {tx_data_i[6:0], 1'b0};
                            oe_d       = ~tx_data_i[7];
                            cnt_d      = 4'd1;
                            state_d    = S_TX;
                        end else begin
                            oe_d    = 1'b0;
                            state_d = S_RX;
                        end
                    end
                end
                S_RX: begin
                    if (scl_rise && cnt_q < 4'd8) begin
                        shift_d = {shift_q[6:0], sda_s};
                        cnt_d   = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            rx_data_d  = {shift_q[6:0], sda_s};
                            rx_valid_d = 1'b1;
                        end
                    end else if (scl_fall && cnt_q == 4'd8) begin
                        state_d = S_RX_ACK;
                        oe_d    = ack_q;
                    end
                end
                S_RX_ACK: begin
                    if (scl_fall) begin
                        oe_d  = 1'b0;
                        cnt_d = '0;
                        state_d = ack_q ? S_RX : S_WAIT_STOP;
                    end
                end
                S_TX: begin
                    // cnt_q counts bits already placed on the bus.
                    if (scl_fall) begin
                        if (cnt_q == 4'd8) begin
                            state_d = S_TX_ACK;
                            oe_d    = 1'b0;
                        end else begin
                            oe_d       = ~tx_shift_q[7];
                            tx_shift_d = {tx_shift_q[6:0], 1'b0};
                            cnt_d      = cnt_q + 4'd1;
                        end
                    end
                end
                S_TX_ACK: begin
                    if (scl_rise) begin
                        mack_d = ~sda_s;
                    end else if (scl_fall) begin
                        if (mack_q) begin
                            tx_load    = 1'b1;
                            tx_shift_d = {tx_data_i[6:0], 1'b0};
                            oe_d       = ~tx_data_i[7];
                            cnt_d      = 4'd1;
                            state_d    = S_TX;
                        end else begin
                            state_d = S_WAIT_STOP;
                        end
                    end
                end
                S_WAIT_STOP: begin
                    oe_d = 1'b0;
                end
                default: begin
                    // S_IDLE: wait for START
                end
            endcase
        end
    end

    assign sda_oe_o   = oe_q;
    assign busy_o     = busy_q;
    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;
    assign tx_load_o  = tx_load;

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: bit-banged I2C master with open-drain SDA model.
// Expected receive bytes and expected read bytes are queued by the stimulus;
// independent monitors pop and compare when the DUT presents them.
module tb_i2c_slave;
    localparam int Q = 6;  // clk cycles per quarter SCL period

    logic       clk = 1'b0;
    logic       rst;
    logic       scl_m;
    logic       sda_m;
    logic       sda_bus;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ack;
    logic [7:0] tx_data;
    logic       tx_load;
    logic       busy;

    always #5 clk = ~clk;

    assign sda_bus = sda_m & ~sda_oe;

    i2c_slave #(.ADDR(7'h42), .SYNC_STAGES(2)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .scl_i      (scl_m),
        .sda_i      (sda_bus),
        .sda_oe_o   (sda_oe),
        .rx_data_o  (rx_data),
        .rx_valid_o (rx_valid),
        .rx_ack_i   (rx_ack),
        .tx_data_i  (tx_data),
        .tx_load_o  (tx_load),
        .busy_o     (busy)
    );

    int total = 0;
    int bad   = 0;

    int rx_cnt      = 0;
    int tx_load_cnt = 0;
    int oe_cnt      = 0;
    int busy_cnt    = 0;

    logic [7:0] exp_rx[$];
    logic [7:0] exp_tx[$];

    logic       rd_mon_en = 1'b0;
    logic [7:0] rd_shift  = 8'h00;
    int         rd_bits   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Receive-side monitor: every rx_valid pulse must match the head of exp_rx.
    always @(negedge clk) begin
        if (sda_oe)  oe_cnt++;
        if (busy)    busy_cnt++;
        if (tx_load) tx_load_cnt++;
        if (rx_valid) begin
            rx_cnt++;
            if (exp_rx.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rx_unexpected: got %0h expected no byte", rx_data);
            end else begin
                chk("rx_byte", 32'(rx_data), 32'(exp_rx.pop_front()));
            end
        end
    end

    // Read-side monitor: assemble SDA bits at each SCL rise of a read byte.
    always @(posedge scl_m) begin
        if (rd_mon_en) begin
            rd_shift = {rd_shift[6:0], sda_bus};
            rd_bits++;
            if (rd_bits == 8) begin
                rd_bits = 0;
                if (exp_tx.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rd_unexpected: got %0h expected no byte", rd_shift);
                end else begin
                    chk("rd_byte", 32'(rd_shift), 32'(exp_tx.pop_front()));
                end
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_bit(input logic b, output logic smp, output logic oe_smp);
        wait_clk(Q);
        sda_m = b;
        wait_clk(Q);
        scl_m = 1'b1;
        wait_clk(Q);
        smp    = sda_bus;
        oe_smp = sda_oe;
        wait_clk(Q);
        scl_m = 1'b0;
    endtask

    task automatic i2c_start();
        wait_clk(Q);
        sda_m = 1'b1;
        wait_clk(Q);
        scl_m = 1'b1;
        wait_clk(Q);
        sda_m = 1'b0;
        wait_clk(Q);
        scl_m = 1'b0;
    endtask

    // STOP; when chk_busy is set, busy must fall exactly 3 clk after the SDA rise.
    task automatic i2c_stop(input logic chk_busy, input string tag);
        wait_clk(Q);
        sda_m = 1'b0;
        wait_clk(Q);
        scl_m = 1'b1;
        wait_clk(Q);
        sda_m = 1'b1;
        if (chk_busy) begin
            wait_clk(2);
            chk({tag, "_busy_before_stop_seen"}, 32'(busy), 32'd1);
            wait_clk(1);
            chk({tag, "_busy_after_stop"}, 32'(busy), 32'd0);
        end
        wait_clk(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack_bus, output logic ack_oe);
        logic s, o;
        for (int i = 7; i >= 0; i--) bus_bit(d[i], s, o);
        bus_bit(1'b1, ack_bus, ack_oe);
    endtask

    task automatic read_byte(input logic [7:0] expv, input logic mnack, input logic [7:0] next_tx);
        logic s, o;
        exp_tx.push_back(expv);
        rd_mon_en = 1'b1;
        for (int i = 0; i < 8; i++) bus_bit(1'b1, s, o);
        rd_mon_en = 1'b0;
        tx_data = next_tx;
        bus_bit(mnack, s, o);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic a, o, s;
        int rx0, tl0, oe0, bz0;

        rst     = 1'b1;
        scl_m   = 1'b1;
        sda_m   = 1'b1;
        rx_ack  = 1'b1;
        tx_data = 8'h00;
        wait_clk(4);
        chk("rst_sda_oe",   32'(sda_oe),   32'd0);
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_tx_load",  32'(tx_load),  32'd0);
        chk("rst_busy",     32'(busy),     32'd0);
        chk("rst_rx_data",  32'(rx_data),  32'd0);
        rst = 1'b0;
        wait_clk(4);

        // T1: write A5 to 0x42 with ACK
        rx0 = rx_cnt;
        i2c_start();
        write_byte({7'h42, 1'b0}, a, o);
        chk("t1_addr_ack_bus", 32'(a), 32'd0);
        chk("t1_addr_ack_oe",  32'(o), 32'd1);
        rx_ack = 1'b1;
        exp_rx.push_back(8'hA5);
        write_byte(8'hA5, a, o);
        chk("t1_data_ack_bus", 32'(a), 32'd0);
        chk("t1_data_ack_oe",  32'(o), 32'd1);
        chk("t1_busy", 32'(busy), 32'd1);
        i2c_stop(1'b1, "t1");
        chk("t1_rx_count", rx_cnt - rx0, 32'd1);

        // T2: wrong address 0x43, nothing may respond
        rx0 = rx_cnt; oe0 = oe_cnt; bz0 = busy_cnt;
        i2c_start();
        write_byte({7'h43, 1'b0}, a, o);
        chk("t2_addr_nack_bus", 32'(a), 32'd1);
        write_byte(8'h11, a, o);
        chk("t2_data_nack_bus", 32'(a), 32'd1);
        i2c_stop(1'b0, "t2");
        chk("t2_oe_cycles",   oe_cnt - oe0,   32'd0);
        chk("t2_busy_cycles", busy_cnt - bz0, 32'd0);
        chk("t2_rx_count",    rx_cnt - rx0,   32'd0);

        // T3: read 3C (master ACK) then C3 (master NACK)
        tl0 = tx_load_cnt;
        tx_data = 8'h3C;
        i2c_start();
        write_byte({7'h42, 1'b1}, a, o);
        chk("t3_addr_ack_bus", 32'(a), 32'd0);
        read_byte(8'h3C, 1'b0, 8'hC3);
        read_byte(8'hC3, 1'b1, 8'h00);
        i2c_stop(1'b1, "t3");
        chk("t3_tx_loads", tx_load_cnt - tl0, 32'd2);
        chk("t3_idle_oe",  32'(sda_oe), 32'd0);
        chk("t3_idle_busy", 32'(busy), 32'd0);

        // T4: first byte NACKed by fabric, second byte ignored
        rx0 = rx_cnt;
        i2c_start();
        write_byte({7'h42, 1'b0}, a, o);
        chk("t4_addr_ack_bus", 32'(a), 32'd0);
        rx_ack = 1'b0;
        exp_rx.push_back(8'h01);
        write_byte(8'h01, a, o);
        chk("t4_b1_nack_bus", 32'(a), 32'd1);
        chk("t4_b1_nack_oe",  32'(o), 32'd0);
        write_byte(8'h02, a, o);
        chk("t4_b2_nack_bus", 32'(a), 32'd1);
        i2c_stop(1'b1, "t4");
        chk("t4_rx_count", rx_cnt - rx0, 32'd1);
        rx_ack = 1'b1;

        // T5: write 55, repeated START, read 99
        rx0 = rx_cnt; tl0 = tx_load_cnt;
        tx_data = 8'h99;
        i2c_start();
        write_byte({7'h42, 1'b0}, a, o);
        chk("t5_waddr_ack_bus", 32'(a), 32'd0);
        exp_rx.push_back(8'h55);
        write_byte(8'h55, a, o);
        chk("t5_data_ack_bus", 32'(a), 32'd0);
        i2c_start();
        write_byte({7'h42, 1'b1}, a, o);
        chk("t5_raddr_ack_bus", 32'(a), 32'd0);
        read_byte(8'h99, 1'b1, 8'h00);
        i2c_stop(1'b1, "t5");
        chk("t5_rx_count", rx_cnt - rx0, 32'd1);
        chk("t5_tx_loads", tx_load_cnt - tl0, 32'd1);

        // T6: reset while driving bit 4 (a 0) of E0, then a clean write
        tx_data = 8'hE0;
        i2c_start();
        write_byte({7'h42, 1'b1}, a, o);
        chk("t6_addr_ack_bus", 32'(a), 32'd0);
        for (int i = 0; i < 3; i++) bus_bit(1'b1, s, o);
        wait_clk(Q);
        sda_m = 1'b1;
        wait_clk(Q);
        scl_m = 1'b1;
        wait_clk(2);
        chk("t6_pre_reset_oe", 32'(sda_oe), 32'd1);
        rst = 1'b1;
        wait_clk(1);
        rst = 1'b0;
        chk("t6_post_reset_oe",   32'(sda_oe), 32'd0);
        chk("t6_post_reset_busy", 32'(busy),   32'd0);
        wait_clk(Q);
        scl_m = 1'b0;
        rx0 = rx_cnt;
        i2c_start();
        write_byte({7'h42, 1'b0}, a, o);
        chk("t6_addr_ack_bus", 32'(a), 32'd0);
        exp_rx.push_back(8'h7E);
        write_byte(8'h7E, a, o);
        chk("t6_data_ack_bus", 32'(a), 32'd0);
        i2c_stop(1'b1, "t6");
        chk("t6_rx_count", rx_cnt - rx0, 32'd1);

        wait_clk(4);
        chk("exp_rx_drained", exp_rx.size(), 32'd0);
        chk("exp_tx_drained", exp_tx.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
